uart_rx_oversampled: RTL and testbench

//  Asynchronous serial receiver (8 data bits, LSB first, 1 stop bit) for the FPGA UART path.
//  An internal phase accumulator generates a 16x-oversampling tick. A 2-FF synchroniser and
//  3-sample majority vote recover each bit. Delivers bytes via a valid/rd handshake with

---
 rtl/uart_rx_oversampled.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// uart_rx_oversampled: 8N1 UART receiver, 16x phase-accumulator tick, 2-FF sync, 3-sample vote.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1) and drive parity_err.
module uart_rx_oversampled #(
  parameter int FREQ  = 50000000,
  parameter int BAUD  = 115200,
  parameter int ACC_W = 12
) (
  input  logic       CLK50MHZ,
  input  logic       RST,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [ACC_W:0] INC = (ACC_W+1)'(((BAUD << ACC_W) + (FREQ >> 5)) / (FREQ >> 4));

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    BRK    = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic           sync1_q, sync2_q;
  logic [ACC_W:0] acc_q, acc_d;
  logic [3:0]     scnt_q, scnt_d;
  logic [1:0]     samp_q, samp_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;
  logic           ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic           pend_q, pend_d;
  logic           perr_q, perr_d;
`endif

  logic rx_s;
  logic tick;
  logic decide;
  logic decision;

  assign rx_s     = sync2_q;
  assign tick     = acc_q[ACC_W];
  // The tick that advances scnt to 9 carries the bit decision, voting with the samples at 7 and 8.
  assign decide   = tick && (scnt_q == 4'd8);
  assign decision = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

  always_comb begin
    state_d = state_q;
    acc_d   = (state_q == IDLE) ? '0 : ({1'b0, acc_q[ACC_W-1:0]} + INC);
    scnt_d  = tick ? (scnt_q + 4'd1) : scnt_q;
    samp_d  = samp_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
`ifdef UART_RX_PARITY_EN
    pend_d  = pend_q;
    perr_d  = perr_q;
`endif

    if (tick && (scnt_q == 4'd6)) samp_d[0] = rx_s;
    if (tick && (scnt_q == 4'd7)) samp_d[1] = rx_s;

    if (valid_q && rd) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        scnt_d = 4'd0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (decide) begin
          if (decision) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = 3'd0;
          end
        end
      end
      DATA: begin
        if (decide) begin
          shift_d = {decision, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (decide) begin
          pend_d  = decision ^ (^shift_q);
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (decide) begin
          data_d  = shift_q;
          ferr_d  = ~decision;
          valid_d = 1'b1;
          if (valid_q && !rd) ovr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          perr_d  = pend_q;
`endif
          state_d = decision ? IDLE : BRK;
        end
      end
      BRK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      acc_q   <= '0;
      scnt_q  <= 4'd0;
      samp_q  <= 2'b11;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pend_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync1_q <= rx;
      sync2_q <= sync1_q;
      acc_q   <= acc_d;
      scnt_q  <= scnt_d;
      samp_q  <= samp_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      pend_q  <= pend_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for uart_rx_oversampled: frame-level model of the byte/flag registers plus directed and random frames.
module tb_uart_rx_oversampled;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, overrun, busy;

  always #10 clk = ~clk;

  uart_rx_oversampled dut (
    .CLK50MHZ  (clk),
    .RST       (rst_n),
    .rx        (rx),
    .rd        (rd),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  localparam real BIT_NS = 1.0e9 / 115200.0;

  int  checks = 0;
  int  errors = 0;
  bit  settling = 1'b1;

  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ferr  = 1'b0;
  logic       m_perr  = 1'b0;
  logic       m_ovr   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Outside frame windows the line is idle, so every output must match the model and busy must be low.
  always @(negedge clk) begin
    if (rst_n && !settling) begin
      checks++;
      if ({valid, data, frame_err, parity_err, overrun, busy} !==
          {m_valid, m_data, m_ferr, m_perr, m_ovr, 1'b0}) begin
        errors++;
        $display("FAIL cycle_compare t=%0t actual v=%b d=%h fe=%b pe=%b ov=%b bz=%b required v=%b d=%h fe=%b pe=%b ov=%b bz=0",
                 $time, valid, data, frame_err, parity_err, overrun, busy,
                 m_valid, m_data, m_ferr, m_perr, m_ovr);
      end
    end
  end

  task automatic model_deliver(input logic [7:0] b, input bit par, input bit stop);
    if (m_valid) m_ovr = 1'b1;
    m_valid = 1'b1;
    m_data  = b;
    m_ferr  = ~stop;
`ifdef UART_RX_PARITY_EN
    m_perr  = (par != ^b);
`else
    m_perr  = 1'b0;
`endif
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par, input bit stop,
                            input real bt, input bit rel);
    settling = 1'b1;
    rx = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bt);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    #(bt);
`endif
    rx = stop;
    #(bt);
    model_deliver(b, par, stop);
    if (rel) begin
      rx = 1'b1;
      repeat (5) @(posedge clk);
      #1 settling = 1'b0;
    end
  endtask

  task automatic do_rd();
    @(posedge clk);
    #2 rd = 1'b1;
    @(posedge clk);
    #1 rd = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  initial begin
    #1950000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] b;
    bit stop, par;
    real bt;

    rst_n = 1'b0;
    rx    = 1'b1;
    #10000;
    check("reset_valid", valid, 0);
    check("reset_data", data, 8'h00);
    check("reset_flags", {frame_err, parity_err, overrun}, 0);
    check("reset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 settling = 1'b0;

    // Nominal-rate 0xA5 with start-edge-to-valid latency
    n = 0;
    fork
      send_frame(8'hA5, ^8'hA5, 1'b1, BIT_NS, 1'b1);
      begin
        while (!valid && n < 6000) begin
          @(posedge clk);
          #1 n++;
        end
      end
    join
    checks++;
    if (n < 4145 || n > 4165) begin
      errors++;
      $display("FAIL latency actual=%0d clocks required=4145..4165", n);
    end
    check("a5_data", data, 8'hA5);
    check("a5_valid", valid, 1);
    check("a5_ferr", frame_err, 0);
    do_rd();
    check("a5_rd_valid", valid, 0);

    // 2 us glitch: START rejects it
    settling = 1'b1;
    rx = 1'b0;
    #1000;
    check("glitch_busy", busy, 1);
    #1000;
    rx = 1'b1;
    #8000;
    settling = 1'b0;
    check("glitch_idle", busy, 0);
    check("glitch_novalid", valid, 0);

    // Low stop bit then held break
    send_frame(8'h3C, ^8'h3C, 1'b0, BIT_NS, 1'b0);
    #3000;
    check("brk_busy", busy, 1);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 settling = 1'b0;
    check("brk_data", data, 8'h3C);
    check("brk_ferr", frame_err, 1);
    check("brk_idle", busy, 0);
    do_rd();
    send_frame(8'h55, ^8'h55, 1'b1, BIT_NS, 1'b1);
    check("x55_data", data, 8'h55);
    check("x55_ferr", frame_err, 0);
    do_rd();

    // Back-to-back without rd
    send_frame(8'h11, ^8'h11, 1'b1, BIT_NS, 1'b0);
    send_frame(8'h22, ^8'h22, 1'b1, BIT_NS, 1'b1);
    check("ovr_data", data, 8'h22);
    check("ovr_valid", valid, 1);
    check("ovr_flag", overrun, 1);
    do_rd();
    check("ovr_cleared", overrun, 0);
    check("ovr_rd_valid", valid, 0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h01, 1'b0, 1'b1, BIT_NS, 1'b1);
    check("par_bad", parity_err, 1);
    do_rd();
    send_frame(8'h01, 1'b1, 1'b1, BIT_NS, 1'b1);
    check("par_good", parity_err, 0);
    do_rd();
`endif

    // Line 3% fast
    send_frame(8'hA5, ^8'hA5, 1'b1, BIT_NS / 1.03, 1'b1);
    check("fast_data", data, 8'hA5);
    check("fast_ferr", frame_err, 0);
    do_rd();

    for (int k = 0; k < 7; k++) begin
      #($urandom_range(200, 5000));
      b    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      par  = (^b) ^ ($urandom_range(0, 3) == 0);
      bt   = BIT_NS * (1.0 + (real'($urandom_range(0, 40)) - 20.0) / 1000.0);
      send_frame(b, par, stop, bt, 1'b1);
      if ($urandom_range(0, 1) == 1) do_rd();
    end

    #1000;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
